insn_feeder: RTL and testbench

//  Upstream instruction source for the CPU/regfile/RAM top level.
//  - Buffers host-supplied 32-bit instructions in a FIFO and issues at most one per cycle on insnToUse/activeInsn.
//  - Idles with activeInsn=0 (NOP) when empty.
//  - Serves register-readback requests: drains the pipeline, drives regToRead/reading, captures regVal.

---
 rtl/insn_feeder_pkg.sv | 14 +
 rtl/insn_feeder_sync_fifo.sv | 59 +++++
 rtl/insn_feeder.sv | 127 ++++++++++++
 tb/tb_insn_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_feeder_pkg.sv
// Shared types and constants for the instruction feeder.
package insn_feeder_pkg;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        DRAIN   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSN  = 32'h0;
    localparam int          REG_IDX_W = 5;

endpackage

// File: rtl/insn_feeder_sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout always shows the current head.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards make the FIFO safe even if a caller pushes when full or pops when empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/insn_feeder.sv
// Buffers host instructions and issues one per cycle to the CPU; services
// register readbacks by draining the pipeline and sampling the regfile port.
module insn_feeder
    import insn_feeder_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    input  logic                   rd_req,
    input  logic [REG_IDX_W-1:0]   rd_reg,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [31:0]            rd_data,
    output logic [31:0]            insnToUse,
    output logic                   activeInsn,
    output logic [REG_IDX_W-1:0]   regToRead,
    output logic                   reading,
    input  logic [31:0]            regVal,
    output logic [$clog2(DEPTH):0] fifo_count,
    output state_t                 fsm_state
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [DW-1:0]          drain_cnt;
    logic [REG_IDX_W-1:0]   rd_reg_q;
    logic                   accept_rd;
    logic                   pop;
    logic                   push;
    logic                   full;
    logic                   empty;
    logic [31:0]            head;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid, and rd_req must be held until rd_ready.
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign fsm_state = state;

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (in_data),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );

    always_comb begin
        state_next = state;
        accept_rd  = 1'b0;
        pop        = 1'b0;
        rd_ready   = 1'b0;
        reading    = 1'b0;
        regToRead  = '0;
        case (state)
            ISSUE: begin
                rd_ready = 1'b1;
                // A readback takes priority over issuing the head this cycle.
                if (rd_req) begin
                    accept_rd  = 1'b1;
                    state_next = DRAIN;
                end else begin
                    pop = !empty;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = READ;
                end
            end
            READ: begin
                reading    = 1'b1;
                regToRead  = rd_reg_q;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                reading    = 1'b1;
                regToRead  = rd_reg_q;
                state_next = ISSUE;
            end
            default: state_next = ISSUE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ISSUE;
            drain_cnt  <= '0;
            rd_reg_q   <= '0;
            activeInsn <= 1'b0;
            insnToUse  <= NOP_INSN;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            state <= state_next;
            if (accept_rd) begin
                drain_cnt <= DRAIN_LOAD;
                rd_reg_q  <= rd_reg;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            activeInsn <= pop;
            insnToUse  <= pop ? head : NOP_INSN;
            // rd_valid is raised together with the freshly captured rd_data.
            rd_valid   <= (state == CAPTURE);
            if (state == CAPTURE) begin
                rd_data <= regVal;
            end
        end
    end

endmodule

// File: tb/tb_insn_feeder.sv
// Self-checking bench for insn_feeder: vector table plus readback, full/wrap and reset sequences.
module tb_insn_feeder;
    import insn_feeder_pkg::*;

    localparam int DEPTH        = 16;
    localparam int DRAIN_CYCLES = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        rd_req;
    logic [4:0]  rd_reg;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] insnToUse;
    logic        activeInsn;
    logic [4:0]  regToRead;
    logic        reading;
    logic [31:0] regVal;
    logic [4:0]  fifo_count;
    state_t      fsm_state;

    logic [31:0] regfile [32];
    logic [31:0] exp_q [$];
    logic [31:0] last_insn;
    int          n_tests = 0;
    int          n_fail  = 0;

    insn_feeder #(
        .DEPTH(DEPTH),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_req    (rd_req),
        .rd_reg    (rd_reg),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .insnToUse (insnToUse),
        .activeInsn(activeInsn),
        .regToRead (regToRead),
        .reading   (reading),
        .regVal    (regVal),
        .fifo_count(fifo_count),
        .fsm_state (fsm_state)
    );

    always #5 clock = ~clock;

    assign regVal = regfile[regToRead];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver: called at a negedge, applies inputs for the next rising edge,
    // records accepted words in the scoreboard, returns at the following negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic req, input logic [4:0] r);
        in_valid = v;
        in_data  = d;
        rd_req   = req;
        rd_reg   = r;
        #1;
        if (v && in_ready) exp_q.push_back(d);
        @(negedge clock);
    endtask

    // Scoreboard: every issued instruction must be the oldest accepted word.
    always @(negedge clock) begin
        if (!reset && activeInsn) begin
            last_insn = insnToUse;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_unexpected: got 0x%08h expected none", insnToUse);
            end else begin
                check("issue_order", insnToUse, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic [4:0]  exp_count;
        logic        exp_active;
        logic [31:0] exp_insn;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int nop_cyc;
        int rd_cyc;
        int pulses;
        int first_rej;
        bit seen;

        for (int i = 0; i < 32; i++) regfile[i] = 32'h0101_0101 * i;
        regfile[5] = 32'hDEAD_BEEF;

        vecs[0]  = '{1'b1, 32'h0000_0001, 5'd1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0002, 5'd1, 1'b1, 32'h1};
        vecs[2]  = '{1'b1, 32'h0000_0003, 5'd1, 1'b1, 32'h2};
        vecs[3]  = '{1'b0, 32'h0,         5'd0, 1'b1, 32'h3};
        vecs[4]  = '{1'b0, 32'h0,         5'd0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_00A5, 5'd1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,         5'd0, 1'b1, 32'hA5};
        vecs[7]  = '{1'b1, 32'h0000_00B6, 5'd1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_00C7, 5'd1, 1'b1, 32'hB6};
        vecs[9]  = '{1'b0, 32'h0,         5'd0, 1'b1, 32'hC7};
        vecs[10] = '{1'b0, 32'h0,         5'd0, 1'b0, 32'h0};

        // Clock/reset
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        rd_req   = 1'b0;
        rd_reg   = '0;
        repeat (2) @(negedge clock);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_active", 32'(activeInsn), 0);
        check("rst_insn", insnToUse, 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_rd_ready", 32'(rd_ready), 1);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_reading", 32'(reading), 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        @(negedge clock);

        // Stream and empty-push vectors
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].in_valid, vecs[i].in_data, 1'b0, 5'd0);
            check("vec_count", 32'(fifo_count), 32'(vecs[i].exp_count));
            check("vec_active", 32'(activeInsn), 32'(vecs[i].exp_active));
            check("vec_insn", insnToUse, vecs[i].exp_insn);
        end

        // Readback of r5
        step(1'b0, 32'h0, 1'b1, 5'd5);
        nop_cyc = 0;
        rd_cyc  = 0;
        pulses  = 0;
        for (int i = 0; i < 20; i++) begin
            if (reading) begin
                rd_cyc++;
                check("read_reg", 32'(regToRead), 5);
            end else if (rd_cyc == 0) begin
                nop_cyc++;
                check("drain_nop", 32'(activeInsn), 0);
                check("drain_reg", 32'(regToRead), 0);
            end
            if (rd_valid) begin
                pulses++;
                check("rd_data_r5", rd_data, 32'hDEAD_BEEF);
            end
            step(1'b0, 32'h0, 1'b0, 5'd0);
        end
        check("drain_cycles", nop_cyc, DRAIN_CYCLES);
        check("reading_cycles", rd_cyc, 2);
        check("rd_valid_pulses", pulses, 1);
        check("rd_data_held", rd_data, 32'hDEAD_BEEF);

        // Simultaneous rd_req and push with two words queued
        step(1'b0, 32'h0, 1'b1, 5'd9);
        step(1'b1, 32'h51, 1'b1, 5'd9);
        step(1'b1, 32'h52, 1'b1, 5'd9);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rd_ready) seen = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 5'd9);
        end
        check("sim_reach_issue", 32'(seen), 1);
        check("sim_count_before", 32'(fifo_count), 2);
        step(1'b1, 32'h53, 1'b1, 5'd9);
        check("sim_count_after", 32'(fifo_count), 3);
        check("sim_no_pop", 32'(activeInsn), 0);
        check("sim_rd_ready", 32'(rd_ready), 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rd_valid) check("rd_data_r9", rd_data, 32'h0909_0909);
            if (activeInsn) begin
                seen = 1'b1;
                check("sim_resume_head", insnToUse, 32'h51);
            end else begin
                step(1'b0, 32'h0, 1'b0, 5'd0);
            end
        end
        check("sim_resumed", 32'(seen), 1);
        repeat (6) step(1'b0, 32'h0, 1'b0, 5'd0);
        check("sim_q_empty", exp_q.size(), 0);
        check("sim_count_end", 32'(fifo_count), 0);

        // Fill past full while rd_req keeps the feeder from popping
        first_rej = -1;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready && first_rej < 0) first_rej = i;
            step(1'b1, 32'(i + 1), 1'b1, 5'd3);
        end
        check("full_first_reject", first_rej, 16);
        check("full_count", 32'(fifo_count), 16);
        check("full_in_ready", 32'(in_ready), 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rd_ready) seen = 1'b1;
            else step(1'b0, 32'h0, 1'b0, 5'd0);
        end
        check("full_reach_issue", 32'(seen), 1);
        check("full_count_at_pop", 32'(fifo_count), 16);
        check("full_pop_in_ready", 32'(in_ready), 0);
        step(1'b1, 32'h99, 1'b0, 5'd0);
        check("full_count_after_pop", 32'(fifo_count), 15);
        repeat (20) step(1'b0, 32'h0, 1'b0, 5'd0);
        check("wrap_last_word", last_insn, 32'd16);
        check("wrap_q_empty", exp_q.size(), 0);
        check("wrap_count", 32'(fifo_count), 0);

        // Asynchronous reset mid-stream with 7 words queued
        for (int i = 0; i < 7; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 5'd2);
        check("pre_rst_count", 32'(fifo_count), 7);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_active", 32'(activeInsn), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_rd_ready", 32'(rd_ready), 1);
        check("mid_rst_reading", 32'(reading), 0);
        exp_q.delete();
        in_valid = 1'b0;
        rd_req   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        repeat (3) step(1'b0, 32'h0, 1'b0, 5'd0);
        check("post_rst_count", 32'(fifo_count), 0);
        check("post_rst_active", 32'(activeInsn), 0);
        check("post_rst_rd_valid", 32'(rd_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
